// File: rtl/hidden_cpu_pkg.sv
// hidden_cpu_pkg: opcode, SYS sub-code and FSM state types
// shared by the core, the ALU and the instruction-source side.
package hidden_cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_XOR,
    OP_MOV,
    OP_ST,
    OP_LD,
    OP_SYS
  } opcode_t;

  localparam int SYS_BCS = 0;
  localparam int SYS_TGL = 1;
  localparam int SYS_CLC = 2;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_EXEC,
    ST_LOAD
  } state_t;

endpackage

// File: rtl/hidden_cpu_if.sv
// hidden_cpu_if: instruction fetch bus (instr/valid/ready + pc).
// master = instruction source, slave = core.
interface hidden_cpu_if #(
  parameter int NREG = 4,
  parameter int PC_W = 8
);
  localparam int RA_W    = $clog2(NREG);
  localparam int INSTR_W = 3 + 2 * RA_W;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [PC_W-1:0]    pc;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready,
    input  pc
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready,
    output pc
  );
endinterface

// File: rtl/hidden_cpu_alu.sv
// hidden_cpu_alu: combinational ALU. in: op, a, b.
// out: res, cOut (carry / borrow), flagWe (op updates carry).
module hidden_cpu_alu
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              cOut,
  output logic              flagWe
);

  always_comb begin
    res    = a;
    cOut   = 1'b0;
    flagWe = 1'b0;
    case (op)
      OP_ADD: begin
        {cOut, res} = {1'b0, a} + {1'b0, b};
        flagWe      = 1'b1;
      end
      OP_SUB: begin
        // bit DATA_W of the widened difference is the borrow
        {cOut, res} = {1'b0, a} - {1'b0, b};
        flagWe      = 1'b1;
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      OP_MOV: res = b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/hidden_cpu_core.sv
// hidden_cpu_core: parametrised register CPU. ports: clk, rst,
// bus (instr fetch slave), carry, dout (r[NREG-1] or pc).
module hidden_cpu_core
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NREG      = 4,
  parameter int MEM_DEPTH = 16,
  parameter int PC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  hidden_cpu_if.slave       bus,
  output logic              carry,
  output logic [DATA_W-1:0] dout
);

  localparam int RA_W    = $clog2(NREG);
  localparam int ADDR_W  = $clog2(MEM_DEPTH);
  localparam int INSTR_W = 3 + 2 * RA_W;

  opcode_t          op;
  logic [RA_W-1:0]  ra;
  logic [RA_W-1:0]  rb;

  assign op = opcode_t'(bus.instr[INSTR_W-1 -: 3]);
  assign ra = bus.instr[2*RA_W-1 -: RA_W];
  assign rb = bus.instr[RA_W-1:0];

  logic [DATA_W-1:0] rf  [NREG];
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            stateQ;
  state_t            stateD;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] memAddr;
  logic [RA_W-1:0]   ldDst;
  logic [DATA_W-1:0] rdData;
  logic [PC_W-1:0]   pcQ;
  logic [PC_W-1:0]   brOff;
  logic              outSel;
  logic              ready;
  logic              accept;

  logic [DATA_W-1:0] va;
  logic [DATA_W-1:0] vb;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
  logic              aluFlagWe;

  logic              isSys;
  logic              takeBr;
  logic              regWe;
  logic              wrEn;
  logic [RA_W-1:0]   wrAddr;
  logic [DATA_W-1:0] wrData;

  assign va      = rf[ra];
  assign vb      = rf[rb];
  assign memAddr = vb[ADDR_W-1:0];

  assign ready  = (stateQ == ST_EXEC);
  assign accept = bus.instr_valid && ready;

  assign isSys  = (op == OP_SYS);
  assign takeBr = isSys && (rb == RA_W'(SYS_BCS)) && carry;
  assign regWe  = (op != OP_ST) && (op != OP_LD) && !isSys;

  // signed cast widens by sign, narrower PC simply truncates
  assign brOff = PC_W'(signed'(va));

  assign bus.instr_ready = ready;
  assign bus.pc          = pcQ;
  assign dout = outSel ? DATA_W'(pcQ) : rf[NREG-1];

  hidden_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (va),
    .b      (vb),
    .res    (aluRes),
    .cOut   (aluCarry),
    .flagWe (aluFlagWe)
  );

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_CLEAR:
        if (clrCnt == ADDR_W'(MEM_DEPTH - 1))
          stateD = ST_EXEC;
      ST_EXEC:
        if (accept && op == OP_LD)
          stateD = ST_LOAD;
      ST_LOAD:
        stateD = ST_EXEC;
      default:
        stateD = ST_CLEAR;
    endcase
  end

  // single register write port: load return wins the LOAD cycle
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = ra;
    wrData = aluRes;
    if (stateQ == ST_LOAD) begin
      wrEn   = 1'b1;
      wrAddr = ldDst;
      wrData = rdData;
    end else if (accept && regWe) begin
      wrEn = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= ST_CLEAR;
      clrCnt <= '0;
      pcQ    <= '0;
      carry  <= 1'b0;
      outSel <= 1'b0;
      ldDst  <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == ST_CLEAR)
        clrCnt <= clrCnt + ADDR_W'(1);
      if (accept) begin
        pcQ <= takeBr ? pcQ + brOff : pcQ + PC_W'(1);
        if (aluFlagWe)
          carry <= aluCarry;
        if (isSys && rb == RA_W'(SYS_CLC))
          carry <= 1'b0;
        if (isSys && rb == RA_W'(SYS_TGL))
          outSel <= !outSel;
        if (op == OP_LD)
          ldDst <= ra;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= DATA_W'(i);
    end else if (wrEn) begin
      rf[wrAddr] <= wrData;
    end
  end

  // memory has no reset; the CLEAR walk zeroes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (stateQ == ST_CLEAR)
        mem[clrCnt] <= '0;
      else if (accept && op == OP_ST)
        mem[memAddr] <= va;
      if (accept && op == OP_LD)
        rdData <= mem[memAddr];
    end
  end

endmodule

// File: tb/tb_hidden_cpu_core.sv
// tb_hidden_cpu_core: directed self-checking bench for
// hidden_cpu_core at default parameters.
module tb_hidden_cpu_core;
  import hidden_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       carry;
  logic [7:0] dout;
  int         checks = 0;
  int         failures = 0;

  hidden_cpu_if #(.NREG(4), .PC_W(8)) bus ();

  hidden_cpu_core #(
    .DATA_W    (8),
    .NREG      (4),
    .MEM_DEPTH (16),
    .PC_W      (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .carry (carry),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(opcode_t op, int ra, int rb);
    return {op, 2'(ra), 2'(rb)};
  endfunction

  task automatic do_reset();
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (!bus.instr_ready && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [6:0] ins, input bit hold = 0);
    int n;
    n = 0;
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.instr_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout instr=%h ready=%b required=1", ins, bus.instr_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    issue(enc(OP_MOV, 2, 0));
    for (int i = 0; i < 16; i++) begin
      issue(enc(OP_ST, 3, 2));
      issue(enc(OP_ADD, 2, 1));
    end
    do_reset();
    wait_clear(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL clear_len got=%0d exp=16", n);
    end
    checks++;
    if (bus.pc !== 8'd0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=00", bus.pc);
    end
    checks++;
    if (dout !== 8'd3) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=03", dout);
    end
    checks++;
    if (carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_carry got=%b exp=0", carry);
    end
    issue(enc(OP_MOV, 2, 0));
    for (int i = 0; i < 16; i++) begin
      issue(enc(OP_LD, 3, 2));
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 8'd0) begin
        failures++;
        $display("FAIL clear_word%0d got=%h exp=00", i, dout);
      end
      issue(enc(OP_ADD, 2, 1));
    end
  endtask

  task automatic test_alu();
    int n;
    do_reset();
    wait_clear(n);
    issue(enc(OP_SUB, 0, 1));
    checks++;
    if (carry !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow got=%b exp=1", carry);
    end
    issue(enc(OP_ADD, 0, 1));
    checks++;
    if (carry !== 1'b1) begin
      failures++;
      $display("FAIL add_carry got=%b exp=1", carry);
    end
    issue(enc(OP_SYS, 0, SYS_CLC));
    checks++;
    if (carry !== 1'b0 || bus.pc !== 8'd3) begin
      failures++;
      $display("FAIL clc carry=%b pc=%h exp carry=0 pc=03", carry, bus.pc);
    end
    issue(enc(OP_MOV, 3, 0));
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL add_result got=%h exp=00", dout);
    end
    issue(enc(OP_SUB, 1, 2));
    issue(enc(OP_MOV, 3, 1));
    checks++;
    if (dout !== 8'hFF) begin
      failures++;
      $display("FAIL sub_result got=%h exp=ff", dout);
    end
    issue(enc(OP_AND, 3, 2));
    checks++;
    if (dout !== 8'h02 || carry !== 1'b1) begin
      failures++;
      $display("FAIL and dout=%h carry=%b exp 02/1", dout, carry);
    end
    issue(enc(OP_XOR, 3, 3));
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL xor_self got=%h exp=00", dout);
    end
    issue(enc(OP_ADD, 3, 2));
    checks++;
    if (dout !== 8'h02 || carry !== 1'b0) begin
      failures++;
      $display("FAIL add_nc dout=%h carry=%b exp 02/0", dout, carry);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    wait_clear(n);
    issue(enc(OP_ST, 3, 2));
    issue(enc(OP_LD, 0, 2), 1);
    checks++;
    if (bus.instr_ready !== 1'b0 || bus.pc !== 8'd2) begin
      failures++;
      $display("FAIL ld_stall ready=%b pc=%h exp 0/02", bus.instr_ready, bus.pc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.pc !== 8'd2) begin
      failures++;
      $display("FAIL ld_held ready=%b pc=%h exp 1/02", bus.instr_ready, bus.pc);
    end
    bus.instr_valid = 1'b0;
    issue(enc(OP_MOV, 3, 0));
    checks++;
    if (dout !== 8'd3 || bus.pc !== 8'd3) begin
      failures++;
      $display("FAIL st_ld dout=%h pc=%h exp 03/03", dout, bus.pc);
    end
  endtask

  task automatic test_branch();
    int n;
    do_reset();
    wait_clear(n);
    issue(enc(OP_SUB, 0, 1));
    repeat (4) issue(enc(OP_SYS, 0, 3));
    checks++;
    if (bus.pc !== 8'd5) begin
      failures++;
      $display("FAIL nop_pc got=%h exp=05", bus.pc);
    end
    issue(enc(OP_SYS, 3, SYS_BCS));
    checks++;
    if (bus.pc !== 8'd8) begin
      failures++;
      $display("FAIL bcs_fwd got=%h exp=08", bus.pc);
    end
    issue(enc(OP_MOV, 3, 0));
    issue(enc(OP_SYS, 3, SYS_BCS));
    checks++;
    if (bus.pc !== 8'd8) begin
      failures++;
      $display("FAIL bcs_back got=%h exp=08", bus.pc);
    end
    issue(enc(OP_SYS, 0, SYS_CLC));
    issue(enc(OP_SYS, 3, SYS_BCS));
    checks++;
    if (bus.pc !== 8'd10) begin
      failures++;
      $display("FAIL bcs_nt got=%h exp=0a", bus.pc);
    end
  endtask

  task automatic test_outsel();
    int n;
    do_reset();
    wait_clear(n);
    issue(enc(OP_SYS, 0, SYS_TGL));
    checks++;
    if (dout !== 8'd1) begin
      failures++;
      $display("FAIL tgl_pc got=%h exp=01", dout);
    end
    issue(enc(OP_SYS, 0, SYS_TGL));
    checks++;
    if (dout !== 8'd3) begin
      failures++;
      $display("FAIL tgl_reg got=%h exp=03", dout);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    do_reset();
    wait_clear(n);
    issue(enc(OP_ST, 3, 2));
    issue(enc(OP_LD, 0, 2));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus.instr_ready !== 1'b0 || bus.pc !== 8'd0) begin
      failures++;
      $display("FAIL rst_load ready=%b pc=%h exp 0/00", bus.instr_ready, bus.pc);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear(n);
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL clear_restart got=%0d exp=16", n);
    end
    issue(enc(OP_MOV, 3, 0));
    checks++;
    if (dout !== 8'd0) begin
      failures++;
      $display("FAIL abort_ld got=%h exp=00", dout);
    end
    issue(enc(OP_LD, 3, 2));
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 8'd0) begin
      failures++;
      $display("FAIL reclear got=%h exp=00", dout);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_branch();
    test_outsel();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
